// File: rtl/pal_stream_arbiter.sv
// pal_stream_arbiter
//   Round-robin arbiter that time-shares one 3-bit palindrome evaluator
//   among N serial bit streams. Each stream keeps its own two-bit history
//   and a saturating warm-up count. A granted bit produces a registered
//   result on the next cycle.
//
// Ports
//   clk          - clock, rising edge
//   reset        - asynchronous reset, active low
//   req_i[N]     - stream k presents a new bit
//   bit_i[N]     - serial data bit of stream k
//   clr_i[N]     - discard history of stream k, restart its warm-up
//   gnt_o[N]     - combinational one-hot grant (zero when nothing requests)
//   res_valid_o  - registered: a result is present
//   res_id_o     - registered: stream index of the result (holds when idle)
//   palindrome_o - registered: last three bits of that stream are a palindrome
module pal_stream_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         bit_i,
    input  logic [N-1:0]         clr_i,
    output logic [N-1:0]         gnt_o,
    output logic                 res_valid_o,
    output logic [$clog2(N)-1:0] res_id_o,
    output logic                 palindrome_o
);
    localparam int unsigned IdW = $clog2(N);

    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [N-1:0][1:0] hist_q, hist_d;
    logic [N-1:0][1:0] wcnt_q, wcnt_d;
    logic              res_valid_q, res_valid_d;
    logic [IdW-1:0]    res_id_q, res_id_d;
    logic              res_pal_q, res_pal_d;

    logic [N-1:0]      gnt;
    logic [IdW-1:0]    gnt_id;
    logic [IdW-1:0]    idx;
    logic              gnt_any;

    // Search ptr+1 .. ptr+N; the index wraps naturally since N is a power of two.
    always_comb begin
        gnt     = '0;
        gnt_id  = ptr_q;
        gnt_any = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = ptr_q + IdW'(i);
            if (!gnt_any && req_i[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        // No grants may leak out while the block is held in reset.
        if (!reset) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    assign gnt_o = gnt;

    always_comb begin
        ptr_d       = ptr_q;
        hist_d      = hist_q;
        wcnt_d      = wcnt_q;
        res_valid_d = gnt_any;
        res_id_d    = res_id_q;
        res_pal_d   = 1'b0;

        if (gnt_any) begin
            ptr_d    = gnt_id;
            res_id_d = gnt_id;
            // Evaluated on pre-update context; a same-cycle clear wins.
            res_pal_d = !clr_i[gnt_id] && (wcnt_q[gnt_id] == 2'd2) &&
                        (hist_q[gnt_id][1] == bit_i[gnt_id]);
        end

        for (int unsigned k = 0; k < N; k++) begin
            if (gnt[k]) begin
                if (clr_i[k]) begin
                    // The granted bit becomes the first bit of the fresh history.
                    hist_d[k] = {1'b0, bit_i[k]};
                    wcnt_d[k] = 2'd1;
                end else begin
                    hist_d[k] = {hist_q[k][0], bit_i[k]};
                    wcnt_d[k] = (wcnt_q[k] == 2'd2) ? 2'd2 : wcnt_q[k] + 2'd1;
                end
            end else if (clr_i[k]) begin
                hist_d[k] = 2'b00;
                wcnt_d[k] = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= IdW'(N - 1);
            hist_q      <= '0;
            wcnt_q      <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_pal_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            hist_q      <= hist_d;
            wcnt_q      <= wcnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_pal_q   <= res_pal_d;
        end
    end

    assign res_valid_o  = res_valid_q;
    assign res_id_o     = res_id_q;
    assign palindrome_o = res_pal_q;

endmodule

// File: tb/tb_pal_stream_arbiter.sv
module tb_pal_stream_arbiter;
    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] bits;
    logic [N-1:0] clr;
    logic [N-1:0] gnt_o;
    logic         res_valid_o;
    logic [1:0]   res_id_o;
    logic         palindrome_o;

    pal_stream_arbiter #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req),
        .bit_i        (bits),
        .clr_i        (clr),
        .gnt_o        (gnt_o),
        .res_valid_o  (res_valid_o),
        .res_id_o     (res_id_o),
        .palindrome_o (palindrome_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: each stream's accepted bits since its last clear/reset,
    // kept as a shift word plus a length; arbitration by the last winner.
    longint       m_seq [N];
    int           m_len [N];
    int           m_last;
    logic [N-1:0] mdl_gnt;
    logic         mdl_valid;
    logic [1:0]   mdl_id;
    logic         mdl_pal;

    logic [N-1:0] act_gnt;
    logic         act_valid;
    logic [1:0]   act_id;
    logic         act_pal;

    typedef struct {
        bit           do_rst;
        logic [N-1:0] req;
        logic [N-1:0] bits;
        logic [N-1:0] clr;
        logic [N-1:0] gnt;
        logic         v;
        logic [1:0]   id;
        logic         p;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [N-1:0] q, logic [N-1:0] b, logic [N-1:0] c,
                                logic [N-1:0] g, logic v, logic [1:0] id, logic p);
        vec_t t;
        t.do_rst = r; t.req = q; t.bits = b; t.clr = c;
        t.gnt = g; t.v = v; t.id = id; t.p = p;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_seq[k] = 0;
            m_len[k] = 0;
        end
        m_last = N - 1;
        mdl_id = 2'd0;
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        bits  = '0;
        clr   = '0;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] b, input logic [N-1:0] c);
        int  g;
        bit  found;
        req  = r;
        bits = b;
        clr  = c;
        found = 1'b0;
        g     = 0;
        for (int j = 1; j <= N; j++) begin
            int k;
            k = (m_last + j) % N;
            if (!found && r[k]) begin
                found = 1'b1;
                g     = k;
            end
        end
        mdl_gnt   = '0;
        mdl_valid = found;
        mdl_pal   = 1'b0;
        if (found) begin
            mdl_gnt[g] = 1'b1;
            mdl_id     = 2'(g);
            m_last     = g;
            if (c[g]) begin
                m_seq[g] = longint'(b[g]);
                m_len[g] = 1;
            end else begin
                mdl_pal  = (m_len[g] >= 2) && (m_seq[g][1] == b[g]);
                m_seq[g] = (m_seq[g] << 1) | longint'(b[g]);
                m_len[g] = m_len[g] + 1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (c[k] && !(found && g == k)) begin
                m_seq[k] = 0;
                m_len[k] = 0;
            end
        end
        #1;
        act_gnt = gnt_o;
        @(posedge clk);
        #1;
        act_valid = res_valid_o;
        act_id    = res_id_o;
        act_pal   = palindrome_o;
    endtask

    logic [N-1:0] pend_req;
    logic [N-1:0] pend_bit;
    logic [N-1:0] r_req;
    logic [N-1:0] r_clr;

    initial begin
        reset = 1'b0;
        req   = '1;
        bits  = '1;
        clr   = '0;
        model_reset();

        // Outputs while held in reset, even with every stream requesting.
        @(posedge clk);
        #1;
        check("rst gnt", 32'(gnt_o), 32'h0);
        check("rst valid", 32'(res_valid_o), 32'h0);
        check("rst id", 32'(res_id_o), 32'h0);
        check("rst pal", 32'(palindrome_o), 32'h0);
        do_reset();

        // Stream 0 alone: 1,0,1
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 1));
        // Full request rotation after reset
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0));
        // Streams 0 (1,1,0) and 1 (0,1,0) interleaved, losers hold their bit
        tbl.push_back(mk(1, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0001, 4'b0000, 4'b0010, 1, 2'd1, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0011, 4'b0000, 4'b0001, 1, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1, 0));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 1));
        // Stream 2: 1,0, then clear with granted 1, then 0,1
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 1));
        // Idle gap: result drops, id holds, pointer and history survive
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 1));

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            tick(tbl[i].req, tbl[i].bits, tbl[i].clr);
            check($sformatf("vec%0d gnt", i), 32'(act_gnt), 32'(tbl[i].gnt));
            check($sformatf("vec%0d valid", i), 32'(act_valid), 32'(tbl[i].v));
            check($sformatf("vec%0d id", i), 32'(act_id), 32'(tbl[i].id));
            check($sformatf("vec%0d pal", i), 32'(act_pal), 32'(tbl[i].p));
        end

        // Reset mid-operation: stream 0 sends 1,0, reset, then 1 -> warm-up restarted
        do_reset();
        tick(4'b0001, 4'b0001, 4'b0000);
        tick(4'b0001, 4'b0000, 4'b0000);
        check("midrst pre valid", 32'(act_valid), 32'h1);
        reset = 1'b0;
        req   = 4'b0001;
        bits  = 4'b0001;
        #1;
        check("midrst gnt", 32'(gnt_o), 32'h0);
        check("midrst valid", 32'(res_valid_o), 32'h0);
        check("midrst id", 32'(res_id_o), 32'h0);
        check("midrst pal", 32'(palindrome_o), 32'h0);
        @(posedge clk);
        #1;
        check("midrst gnt edge", 32'(gnt_o), 32'h0);
        check("midrst valid edge", 32'(res_valid_o), 32'h0);
        model_reset();
        reset = 1'b1;
        tick(4'b0001, 4'b0001, 4'b0000);
        check("postrst gnt", 32'(act_gnt), 32'h1);
        check("postrst valid", 32'(act_valid), 32'h1);
        check("postrst pal", 32'(act_pal), 32'h0);

        // Randomized traffic against the model; requesters hold until granted.
        do_reset();
        pend_req = '0;
        pend_bit = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) begin
                do_reset();
                pend_req = '0;
            end
            for (int k = 0; k < N; k++) begin
                if (!pend_req[k] && ($urandom_range(0, 2) != 0) && ((cyc % 64) < 56)) begin
                    pend_req[k] = 1'b1;
                    pend_bit[k] = 1'($urandom_range(0, 1));
                end
                r_clr[k] = ($urandom_range(0, 11) == 0);
            end
            r_req = pend_req;
            tick(r_req, pend_bit, r_clr);
            check($sformatf("rnd%0d gnt", cyc), 32'(act_gnt), 32'(mdl_gnt));
            check($sformatf("rnd%0d valid", cyc), 32'(act_valid), 32'(mdl_valid));
            check($sformatf("rnd%0d id", cyc), 32'(act_id), 32'(mdl_id));
            check($sformatf("rnd%0d pal", cyc), 32'(act_pal), 32'(mdl_pal));
            pend_req = pend_req & ~mdl_gnt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pal_stream_arbiter.md
PAL_STREAM_ARBITER -- requirements
Module: pal_stream_arbiter

Interface
REQ-001 SHALL provide parameter N, default 4, the number of serial bit streams sharing one 3-bit palindrome evaluator (N >= 2, power of two).
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL provide port req_i  input  N  bit k high = stream k presents a new bit this cycle.
REQ-005 SHALL provide port bit_i  input  N  bit k = serial data bit of stream k, valid when req_i[k]=1.
REQ-006 SHALL provide port clr_i  input  N  bit k high = discard the history of stream k and restart its warm-up.
REQ-007 SHALL provide port gnt_o  output  N  one-hot (or zero) combinational grant; bit k consumed when req_i[k] & gnt_o[k].
REQ-008 SHALL provide port res_valid_o  output  1  registered; a result is present this cycle.
REQ-009 SHALL provide port res_id_o  output  log2(N)  registered; index of the stream the result belongs to.
REQ-010 SHALL provide port palindrome_o  output  1  registered; 1 = last three bits of stream res_id_o form a palindrome.

Function
REQ-011 SHALL keep a per-stream context: hist[1:0] (two previous bits, hist[1] oldest) and warm-up count wcnt in 0..2 (saturating).
REQ-012 SHALL hold a round-robin pointer ptr; priority order is ptr+1, ptr+2, ... modulo N.
REQ-013 SHALL assert gnt_o[k] for the first requesting stream in priority order; gnt_o = 0 when req_i = 0.
REQ-014 SHALL, on a grant to k, load ptr <= k at the clock edge; with no grant ptr holds.
REQ-015 SHALL, one cycle after a grant to k, drive res_valid_o=1, res_id_o=k, palindrome_o = (wcnt_k==2) && (hist_k[1]==bit_i[k]), using pre-update context.
REQ-016 SHALL, at the granting edge, update stream k: hist_k <= {hist_k[0], bit_i[k]}, wcnt_k <= min(wcnt_k+1, 2).
REQ-017 SHALL leave every non-granted stream's context unchanged; requesters that are not granted hold req_i/bit_i (no bit is dropped).
REQ-018 SHALL drive res_valid_o=0 and palindrome_o=0 in any cycle following a cycle without a grant; res_id_o holds its last value.
REQ-019 SHALL, on clr_i[k] without a grant to k, set hist_k=2'b00 and wcnt_k=0 at the clock edge.
REQ-020 SHALL, on clr_i[k] with a grant to k in the same cycle, give clear priority: result palindrome_o=0, then hist_k={1'b0, bit_i[k]}, wcnt_k=1.
REQ-021 SHALL never assert palindrome_o with res_valid_o=0.
REQ-022 SHALL wrap ptr from N-1 to 0 with no skipped or repeated stream under continuous full request.

Reset
REQ-023 SHALL, while reset=0, force gnt_o=0, res_valid_o=0, res_id_o=0, palindrome_o=0, all hist=2'b00, all wcnt=0, ptr=N-1 (stream 0 first priority).
REQ-024 SHALL, on reset assertion mid-operation, discard all contexts and any pending result; the first result after release has wcnt=0 semantics.

Verification
REQ-025 SHALL cover: stream 0 alone sends 1,0,1 on consecutive cycles -> palindrome_o 0,0,1 with res_id_o=0, res_valid_o=1 each following cycle.
REQ-026 SHALL cover: req_i=4'b1111 held 5 cycles after reset -> gnt_o 0001,0010,0100,1000,0001.
REQ-027 SHALL cover: streams 0 and 1 requesting together, stream 0 bits 1,1,0, stream 1 bits 0,1,0 -> stream 0 result 0, stream 1 result 1 on their third grants; contexts do not mix.
REQ-028 SHALL cover: stream 2 sends 1,0, then clr_i[2] with bit 1 granted -> palindrome_o 0; next bits 0,1 -> results 0,1 (window 1,0,1 from post-clear history).
REQ-029 SHALL cover: stream 0 sends 1,0, reset pulsed low, then 1 -> palindrome_o 0 (warm-up restarted), gnt_o=0 and outputs 0 during reset.
REQ-030 SHALL cover: no requests for 3 cycles between grants -> res_valid_o=0 on idle cycles, ptr and contexts unchanged.
